// File: rtl/block_sync_rx.sv
// 64b/66b receive block synchroniser: hunts sync-header alignment with gearbox bit slips, then holds lock.
// Optional BLOCK_SYNC_DBG_EN adds a saturating slip counter output slip_cnt_o.
module block_sync_rx #(
    parameter int HEAD_W     = 2,
    parameter int SH_CNT_MAX = 64,
    parameter int SH_INV_MAX = 16,
    parameter int SLIP_WAIT  = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              lock_v_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
`ifdef BLOCK_SYNC_DBG_EN
    output logic [7:0]        slip_cnt_o,
`endif
    output logic              lock_v_o
);
    localparam int SH_W  = $clog2(SH_CNT_MAX);
    localparam int INV_W = $clog2(SH_INV_MAX + 1);

    typedef enum logic [1:0] {ST_RESET, ST_TEST, ST_SLIP, ST_WAIT} state_t;

    state_t           state_q;
    logic [SH_W-1:0]  sh_cnt_q;
    logic [INV_W-1:0] inv_cnt_q;
    logic [3:0]       wait_cnt_q;
    logic             slip_q;
    logic             lock_q;

    logic sh_valid;
    logic sh_last;
    logic inv_last;
    logic slip_fire;

    assign sh_valid = head_i[1] ^ head_i[0];
    assign sh_last  = (sh_cnt_q == SH_W'(SH_CNT_MAX - 1));
    assign inv_last = (inv_cnt_q == INV_W'(SH_INV_MAX - 1));
    // Invalid header seen while testing: unlocked always slips, locked only on the last tolerated error.
    assign slip_fire = lock_v_i && (state_q == ST_TEST) && valid_i && !sh_valid && (!lock_q || inv_last);

    always_ff @(posedge clk) begin
        if (!nreset || !lock_v_i) begin
            state_q    <= ST_RESET;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            slip_q <= 1'b0;
            case (state_q)
                ST_RESET: state_q <= ST_TEST;
                ST_TEST: begin
                    if (slip_fire) begin
                        state_q   <= ST_SLIP;
                        slip_q    <= 1'b1;
                        lock_q    <= 1'b0;
                        sh_cnt_q  <= '0;
                        inv_cnt_q <= '0;
                    end else if (valid_i) begin
                        if (sh_last) begin
                            lock_q    <= 1'b1;
                            sh_cnt_q  <= '0;
                            inv_cnt_q <= '0;
                        end else begin
                            sh_cnt_q <= sh_cnt_q + 1'b1;
                            if (!sh_valid)
                                inv_cnt_q <= inv_cnt_q + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    state_q    <= ST_WAIT;
                    sh_cnt_q   <= '0;
                    inv_cnt_q  <= '0;
                    wait_cnt_q <= 4'(SLIP_WAIT);
                end
                ST_WAIT: begin
                    if (valid_i) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                        if (wait_cnt_q == 4'd1)
                            state_q <= ST_TEST;
                    end
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

    assign slip_v_o = slip_q;
    assign lock_v_o = lock_q;

`ifdef BLOCK_SYNC_DBG_EN
    logic [7:0] slip_cnt_q;

    // Survives PMA lock loss so slips can be tallied across CDR drops.
    always_ff @(posedge clk) begin
        if (!nreset)
            slip_cnt_q <= '0;
        else if (slip_fire && slip_cnt_q != 8'hFF)
            slip_cnt_q <= slip_cnt_q + 1'b1;
    end

    assign slip_cnt_o = slip_cnt_q;
`endif
endmodule

// File: tb/tb_block_sync_rx.sv
// Bench for block_sync_rx: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an event-level model of the lock rules.
module tb_block_sync_rx;
    localparam int SH_CNT_MAX = 64;
    localparam int SH_INV_MAX = 16;
    localparam int SLIP_WAIT  = 2;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       lock_v_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [1:0] head_i = 2'b00;
    logic       slip_v_o;
    logic       lock_v_o;
`ifdef BLOCK_SYNC_DBG_EN
    logic [7:0] slip_cnt_o;
`endif

    always #5 clk = ~clk;

    block_sync_rx #(
        .HEAD_W(2), .SH_CNT_MAX(SH_CNT_MAX), .SH_INV_MAX(SH_INV_MAX), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .lock_v_i(lock_v_i),
        .valid_i(valid_i),
        .head_i(head_i),
        .slip_v_o(slip_v_o),
`ifdef BLOCK_SYNC_DBG_EN
        .slip_cnt_o(slip_cnt_o),
`endif
        .lock_v_o(lock_v_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the outputs must be after each edge.
    bit m_lock, m_slip, m_in_reset;
    int m_discard, m_seen, m_bad, m_slips;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fire_slip();
        m_slip = 1; m_seen = 0; m_bad = 0;
        if (m_slips < 255) m_slips++;
    endtask

    task automatic model_edge();
        bit good;
        good = head_i[1] ^ head_i[0];
        if (!nreset) begin
            m_lock = 0; m_slip = 0; m_in_reset = 1; m_discard = 0; m_seen = 0; m_bad = 0; m_slips = 0;
        end else if (!lock_v_i) begin
            m_lock = 0; m_slip = 0; m_in_reset = 1; m_discard = 0; m_seen = 0; m_bad = 0;
        end else if (m_in_reset) begin
            m_in_reset = 0;
        end else if (m_slip) begin
            m_slip = 0; m_discard = SLIP_WAIT;
        end else if (m_discard > 0) begin
            if (valid_i) m_discard--;
        end else if (valid_i) begin
            if (!m_lock) begin
                if (!good) fire_slip();
                else begin
                    m_seen++;
                    if (m_seen == SH_CNT_MAX) begin m_lock = 1; m_seen = 0; end
                end
            end else begin
                m_seen++;
                if (!good) m_bad++;
                if (m_bad == SH_INV_MAX) begin m_lock = 0; fire_slip(); end
                else if (m_seen == SH_CNT_MAX) begin m_seen = 0; m_bad = 0; end
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare on the falling edge.
    task automatic step(input logic nr, input logic lv, input logic v, input logic [1:0] h);
        nreset = nr; lock_v_i = lv; valid_i = v; head_i = h;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("slip_v_o", int'(slip_v_o), int'(m_slip));
        check("lock_v_o", int'(lock_v_o), int'(m_lock));
`ifdef BLOCK_SYNC_DBG_EN
        check("slip_cnt_o", int'(slip_cnt_o), m_slips);
`endif
    endtask

    function automatic logic [1:0] good_hd(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        int ninv;
        int nvalid;
        step(0, 1, 1, 2'b01);
        step(0, 1, 1, 2'b11);
        check("reset_lock", int'(lock_v_o), 0);
        check("reset_slip", int'(slip_v_o), 0);

        // Clean alignment: first cycle out of reset is not a test cycle.
        step(1, 1, 0, 2'b00);
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step(1, 1, 1, good_hd(i));
            if (i == SH_CNT_MAX - 2) check("clean_lock_early", int'(lock_v_o), 0);
            check("clean_no_slip", int'(slip_v_o), 0);
        end
        check("clean_lock", int'(lock_v_o), 1);

        // Window with 15 invalid headers keeps lock.
        for (int i = 0; i < SH_CNT_MAX; i++)
            step(1, 1, 1, ((i * 7) % 64 < 15) ? 2'b00 : good_hd(i));
        check("tol15_lock", int'(lock_v_o), 1);

        // Window with 16 invalid headers: lock falls with the slip.
        ninv = 0;
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            if ((i * 5) % 64 < 16) begin
                ninv++;
                step(1, 1, 1, 2'b00);
                if (ninv == 16) begin
                    check("tol16_slip", int'(slip_v_o), 1);
                    check("tol16_lock", int'(lock_v_o), 0);
                    break;
                end
            end else step(1, 1, 1, good_hd(i));
        end

        // Misaligned start: header 11 on the 5th block.
        step(1, 0, 0, 2'b00);
        step(1, 1, 0, 2'b00);
        for (int i = 0; i < 4; i++) step(1, 1, 1, good_hd(i));
        step(1, 1, 1, 2'b11);
        check("mis_slip", int'(slip_v_o), 1);
        for (int i = 0; i < 1 + SLIP_WAIT; i++) begin
            step(1, 1, 1, 2'b11);
            check("mis_ignored", int'(slip_v_o), 0);
        end
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step(1, 1, 1, good_hd(i));
            if (i == SH_CNT_MAX - 2) check("mis_relock_early", int'(lock_v_o), 0);
        end
        check("mis_relock", int'(lock_v_o), 1);

        // PMA lock drop mid-window needs a full fresh window.
        for (int i = 0; i < 10; i++) step(1, 1, 1, good_hd(i));
        step(1, 0, 1, 2'b01);
        check("pma_drop_lock", int'(lock_v_o), 0);
        step(1, 1, 0, 2'b00);
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step(1, 1, 1, good_hd(i));
            if (i == SH_CNT_MAX - 2) check("pma_relock_early", int'(lock_v_o), 0);
        end
        check("pma_relock", int'(lock_v_o), 1);

        // Valid gaps carrying 00 stall but do not disturb the count.
        step(1, 0, 0, 2'b00);
        step(1, 1, 0, 2'b00);
        nvalid = 0;
        while (nvalid < SH_CNT_MAX) begin
            if ($urandom_range(0, 2) == 0) step(1, 1, 0, 2'b00);
            else begin
                step(1, 1, 1, good_hd(nvalid));
                nvalid++;
                check("gap_no_slip", int'(slip_v_o), 0);
                if (nvalid == SH_CNT_MAX - 1) check("gap_lock_early", int'(lock_v_o), 0);
            end
        end
        check("gap_lock", int'(lock_v_o), 1);

        // Randomized traffic with varying error density and occasional PMA drops.
        for (int seg = 0; seg < 8; seg++) begin
            int err_den;
            err_den = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 50 : 4);
            for (int i = 0; i < 400; i++) begin
                logic v;
                logic lv;
                logic [1:0] h;
                v  = ($urandom_range(0, 4) != 0);
                lv = ($urandom_range(0, 299) != 0);
                if (err_den != 0 && $urandom_range(0, err_den - 1) == 0)
                    h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                else h = good_hd(int'($urandom_range(0, 1)));
                if (!v) h = 2'($urandom_range(0, 3));
                step(1, lv, v, h);
            end
        end

`ifdef BLOCK_SYNC_DBG_EN
        // Force more than 255 slips, then confirm which resets clear the counter.
        for (int i = 0; i < 1300; i++) step(1, 1, 1, 2'b11);
        check("dbg_saturate", int'(slip_cnt_o), 255);
        step(1, 0, 0, 2'b00);
        check("dbg_pma_keep", int'(slip_cnt_o), 255);
        step(0, 1, 0, 2'b00);
        check("dbg_nreset_clear", int'(slip_cnt_o), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/block_sync_rx.md
# block_sync_rx

Receive-side block synchronisation controller for the 64b/66b PCS. It sits directly after the rx gearbox and checks the 2-bit sync header of every block the gearbox marks valid. It drives the gearbox bit-slip request until header alignment is found, then asserts block lock for the descrambler and decoder. Lock acquisition and loss follow the 802.3 Clause 49 lock state machine, reduced to a single-clock, cycle-exact form.

## Interface
- HEAD_W, 2: sync header width. Only 2 is supported.
- SH_CNT_MAX, 64: headers per test window; must be a power of two, at least 4.
- SH_INV_MAX, 16: invalid headers in one window that cause loss of lock while locked; must be less than SH_CNT_MAX.
- SLIP_WAIT, 2: valid blocks discarded after a slip before testing resumes; range 1..15.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset: synchronous, active-low.
- lock_v_i  in  1  PMA/CDR lock. Low forces the block into RESET.
- valid_i  in  1  gearbox output holds a complete block this cycle.
- head_i  in  HEAD_W  sync header from the gearbox.
- slip_v_o  out  1  one-cycle request to the gearbox to slip one bit.
- lock_v_o  out  1  block lock.

## Operation
- Sync header check: sh_valid = head_i[1] ^ head_i[0]. Headers 01 and 10 are valid; 00 and 11 are invalid.
- head_i is ignored in every cycle where valid_i is 0.
- Counters:
  - sh_cnt: $clog2(SH_CNT_MAX) bits.
  - inv_cnt: $clog2(SH_INV_MAX+1) bits.
  - wait_cnt: 4 bits.
  - No counter wraps. Each is cleared explicitly before it can overflow.
- State encoding is free.
- RESET: all counters are 0 and lock_v_o is 0. Leave for TEST when nreset=1 and lock_v_i=1.
- TEST with lock_v_o=0, on each valid_i:
  - An invalid header goes to SLIP.
  - Otherwise sh_cnt increments.
  - The SH_CNT_MAX-th consecutive valid header sets lock_v_o=1 and clears sh_cnt. The state stays TEST.
- TEST with lock_v_o=1, on each valid_i:
  - sh_cnt increments.
  - An invalid header also increments inv_cnt.
  - If inv_cnt reaches SH_INV_MAX (counting the current header), clear lock_v_o and go to SLIP.
  - Otherwise, when the SH_CNT_MAX-th header of the window arrives, clear sh_cnt and inv_cnt and stay locked.
- SLIP:
  - slip_v_o=1 for exactly this one cycle.
  - sh_cnt and inv_cnt are cleared.
  - wait_cnt is loaded with SLIP_WAIT.
  - The next state is WAIT unconditionally.
- WAIT:
  - Each valid_i decrements wait_cnt and the header is not checked.
  - When a valid_i arrives with wait_cnt=1, go to TEST. That block is discarded.
- lock_v_i=0 in any state goes to RESET on the next edge. This has priority over all other transitions, including a pending SLIP.
- Simultaneous events in TEST (locked): window end and the SH_INV_MAX-th invalid header on the same block resolve as loss of lock.

## Timing
- Reset values: slip_v_o=0, lock_v_o=0, state RESET, all counters 0.
- All outputs are registered. Neither output has a combinational path from any input.
- An invalid header on valid_i at edge N gives slip_v_o=1 in cycle N+1 and 0 in cycle N+2.
- Lock assertion: lock_v_o rises in the cycle after the edge that samples the SH_CNT_MAX-th valid header.
- Loss of lock: lock_v_o falls in the same cycle that slip_v_o rises.
- slip_v_o pulses are separated by at least SLIP_WAIT+1 valid blocks.
- Gaps in valid_i stall the counters and do not reset them.

## Configuration
- BLOCK_SYNC_DBG_EN:
  - When defined, adds an output port slip_cnt_o (8 bits). It counts slip_v_o pulses and saturates at 255.
  - It is cleared only by nreset=0. lock_v_i=0 does not clear it.
  - When not defined, the port and the counter are absent. All other behaviour is identical.

## Test plan
- Clean alignment:
  - Stimulus: lock_v_i=1, valid_i=1 continuously, head 01/10 alternating.
  - Required: lock_v_o=1 in the cycle after the 64th header. slip_v_o is never asserted.
- Misaligned start:
  - Stimulus: head=11 on the 5th valid block while unlocked.
  - Required: single slip_v_o pulse on the next cycle. The next 2 valid blocks are ignored even if invalid. Testing then restarts with sh_cnt=0.
- Locked tolerance:
  - Stimulus: after lock, a 64-block window containing exactly 15 invalid headers (00).
  - Required: lock_v_o stays 1 and the counters clear at window end.
  - Stimulus: a following window with 16 invalid headers.
  - Required: lock_v_o falls and slip_v_o rises on the cycle after the 16th invalid header.
- Valid gaps:
  - Stimulus: 64 valid headers interleaved with random valid_i=0 cycles that carry head=00.
  - Required: lock is acquired after the 64th valid block exactly, with no slip.
- PMA lock drop:
  - Stimulus: lock_v_i=0 for one cycle while locked, mid-window.
  - Required: lock_v_o=0 next cycle and counters cleared. Lock requires a full 64 fresh headers.
- Debug counter:
  - Condition: BLOCK_SYNC_DBG_EN defined.
  - Stimulus: force 300 slips.
  - Required: slip_cnt_o saturates at 255. A lock_v_i drop does not clear it; nreset does.
